// File: rtl/cdb_broadcaster.sv
// cdb_broadcaster: per-unit result FIFOs drained by a rotating-priority arbiter onto N registered CDB slots
package cdb_pkg;
  localparam int PRF_BITS = 6;
  localparam int ROB_BITS = 5;
  localparam int XLEN = 32;
  typedef struct packed {
    logic                valid;
    logic                value_valid;
    logic [PRF_BITS-1:0] dest_prf;
    logic [ROB_BITS-1:0] rob_entry;
    logic [XLEN-1:0]     value;
  } cdb_t;
endpackage

module cdb_broadcaster
  import cdb_pkg::*;
#(
  parameter int N = 4,
  parameter int NUM_FU = 6,
  parameter int DEPTH = 2
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               flush,
  input  logic [NUM_FU-1:0]                  fu_valid,
  input  logic [NUM_FU-1:0][PRF_BITS-1:0]    fu_dest_prf,
  input  logic [NUM_FU-1:0][ROB_BITS-1:0]    fu_rob_entry,
  input  logic [NUM_FU-1:0]                  fu_value_valid,
  input  logic [NUM_FU-1:0][XLEN-1:0]        fu_value,
  output logic [NUM_FU-1:0]                  fu_ready,
  output cdb_t [N-1:0]                       cdb_out
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int RW = NUM_FU > 1 ? $clog2(NUM_FU) : 1;

  cdb_t mem [NUM_FU][DEPTH];
  logic [PW-1:0] wptr [NUM_FU];
  logic [PW-1:0] rptr [NUM_FU];
  logic [CW-1:0] count [NUM_FU];
  logic [RW-1:0] rr_ptr, last, next_rr;
  logic [RW-1:0] slot_fu [N];
  logic [NUM_FU-1:0] push, grant;
  int ng;

  function automatic int rot(input logic [RW-1:0] base, input int j);
    return (int'(base) + j) % NUM_FU;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      fu_ready[i] = reset && (count[i] < CW'(DEPTH));
      push[i] = fu_valid[i] && fu_ready[i] && !flush;
    end
  end

  // Scan from rr_ptr; the k-th non-empty unit found feeds slot k
  always_comb begin
    grant = '0;
    ng = 0;
    last = rr_ptr;
    for (int k = 0; k < N; k++) slot_fu[k] = '0;
    for (int j = 0; j < NUM_FU; j++) begin
      if (count[rot(rr_ptr, j)] != '0 && ng < N) begin
        grant[rot(rr_ptr, j)] = 1'b1;
        slot_fu[ng] = RW'(rot(rr_ptr, j));
        last = RW'(rot(rr_ptr, j));
        ng++;
      end
    end
    next_rr = ng == 0 ? rr_ptr : (int'(last) == NUM_FU - 1 ? '0 : last + 1'b1);
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_FU; i++)
      if (push[i])
        mem[i][wptr[i]] <= '{1'b1, fu_value_valid[i], fu_dest_prf[i], fu_rob_entry[i], fu_value[i]};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
      cdb_out <= '0;
      for (int i = 0; i < NUM_FU; i++) begin
        count[i] <= '0;
        wptr[i] <= '0;
        rptr[i] <= '0;
      end
    end else if (flush) begin
      cdb_out <= '0;
      for (int i = 0; i < NUM_FU; i++) begin
        count[i] <= '0;
        wptr[i] <= '0;
        rptr[i] <= '0;
      end
    end else begin
      rr_ptr <= next_rr;
      for (int k = 0; k < N; k++)
        cdb_out[k] <= k < ng ? mem[slot_fu[k]][rptr[slot_fu[k]]] : '0;
      for (int i = 0; i < NUM_FU; i++) begin
        if (push[i]) wptr[i] <= wptr[i] + 1'b1;
        if (grant[i]) rptr[i] <= rptr[i] + 1'b1;
        count[i] <= count[i] + CW'(push[i]) - CW'(grant[i]);
      end
    end
  end
endmodule

// File: doc/cdb_broadcaster.md
# cdb_broadcaster

Collects completed results from the functional units and drives up to `N` Common Data Bus (CDB) entries per cycle. These CDB entries are consumed by the PRF, the reservation stations and the ROB. Each functional unit owns a small result FIFO with a valid/ready handshake. A rotating-priority arbiter grants at most one FIFO head per unit per cycle and registers the granted entries onto the CDB.

## Interface
- `N`, default `` `N ``: number of CDB slots (superscalar width).
- `NUM_FU`, default 6: number of functional-unit result ports.
- `DEPTH`, default 2: result FIFO entries per functional unit; power of two, at least 2.
- `clock` input 1: single clock, all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low (asserted when 0).
- `flush` input 1: synchronous squash (mispredict recovery).
- `fu_valid` input `[NUM_FU]`: result offered by the functional unit.
- `fu_dest_prf` input `[NUM_FU][` `` `PRF_NUM_INDEX_BITS `` `]`: destination physical register.
- `fu_rob_entry` input `[NUM_FU][` `` `ROB_NUM_INDEX_BITS `` `]`: ROB index of the instruction.
- `fu_value_valid` input `[NUM_FU]`: result carries a register value (0 for stores and branches).
- `fu_value` input `[NUM_FU][` `` `XLEN `` `]`: result value.
- `fu_ready` output `[NUM_FU]`: FIFO can accept a result this cycle.
- `cdb_out` output `CDB [N]`: registered broadcast with fields `valid`, `value_valid`, `dest_prf`, `rob_entry`, `value`.

## Operation
- Push: at a rising edge where `fu_valid[i] & fu_ready[i]` and `flush==0`, the result is appended to FIFO i.
- `fu_ready[i]` = (count_i < `DEPTH`) and not in reset. It depends only on registered count, not on a same-cycle pop, so a full FIFO never pushes.
- Arbitration is combinational over non-empty FIFO heads.
  - Scan units from `rr_ptr` upward, mod `NUM_FU`.
  - Grant the first up-to-`N` non-empty units, at most one per unit.
  - The k-th grant (k = 0..N-1) goes to CDB slot k.
- Pop: every granted head is popped at the same edge its entry is registered into `cdb_out[k]`.
- Unused slots: `valid=0` and every other field 0.
- `rr_ptr` update:
  - With grants, it becomes (last granted unit + 1) mod `NUM_FU`.
  - With no grants, it is unchanged.
  - A unit left ungranted therefore has highest priority next cycle, which bounds starvation to 1 cycle when at most `N+1` units contend.
- Per-FIFO order is strict FIFO. No entry is lost or duplicated.
- `fu_value_valid`, `fu_dest_prf`, `fu_rob_entry` and `fu_value` pass through unmodified.
- Flush has priority over push and pop. At the flush edge:
  - all FIFOs are emptied;
  - `cdb_out` becomes all-invalid;
  - results offered in the flush cycle are dropped;
  - `rr_ptr` is unchanged.
- Reset (`reset==0`, asynchronous):
  - FIFO counts and pointers become 0;
  - `rr_ptr` becomes 0;
  - `cdb_out` becomes all fields 0;
  - `fu_ready` becomes 0.
  - The first push is accepted at the first rising edge after `reset` returns to 1.

## Timing
- Latency: a result accepted at edge E0 sits in its FIFO during cycle E0→E1. It is granted at E1 at the earliest and is visible on `cdb_out` from E1 to E2. Minimum latency is 1 cycle from acceptance to broadcast.
- Each CDB entry is valid for exactly one cycle; the block has no CDB backpressure.
- Sustained throughput: one result per unit per cycle with `DEPTH>=2`. A unit pushing every cycle while granted every cycle keeps `fu_ready=1`.
- Reset mid-operation: `cdb_out` clears without waiting for a clock edge. Queued results are discarded.

## Test plan
- **Reset:** hold `reset=0` for 2 cycles, then release → during reset, `cdb_out` is all 0 and `fu_ready` is 0x00; after release, `fu_ready=6'b111111`.
- **Single result:** FU2 offers dest_prf=5, rob_entry=3, value=632464, value_valid=1, accepted at edge E0 → `cdb_out[0]` carries exactly those fields from E1 to E2. Slots 1–3 are invalid. All slots are invalid at E2.
- **Full contention (N=4):** all 6 units push once at E0 with `rr_ptr=0` → at E1, slots 0–3 = FU0..FU3 and `rr_ptr=4`. At E2, slots 0,1 = FU4,FU5, slots 2,3 invalid, `rr_ptr=0`.
- **Sustained 5-unit load:** FU0..FU4 each push a per-unit incrementing value whenever ready, for 40 cycles. Required response:
  - the captured CDB stream per unit is in order with no gaps or duplicates;
  - no unit goes more than 1 consecutive cycle without a grant;
  - no `fu_ready` is low for more than 1 consecutive cycle.
- **Flush:** with FU1, FU3 and FU5 each holding 2 entries, assert `flush` for one edge while FU0 offers a result → next cycle, `cdb_out` is all invalid and `fu_ready` is all 1. FU0's result never appears.
- **Asynchronous reset mid-stream:** drop `reset` between edges while `cdb_out[0..2]` are valid → `cdb_out` clears immediately. After release, no stale entry ever broadcasts.
